// File: rtl/apb_timer_bank.sv
// apb_timer_bank
//   NUM_CH independent up-counting timers behind a single zero-wait-state APB
//   slave. Channel c occupies four registers at byte address 4*c:
//     +0 STATUS : [0] START (W1), [1] STOP (W1), [3:2] STATE, [4] RELOAD,
//                 [5] IRQ_EN, [6] DONE (sticky, W1C)
//     +1 GOAL   : compare value (RW)
//     +2 CURR   : current count (RO, writes flag pslverr)
//     +3 PRESC  : prescaler reload, tick every PRESC+1 running cycles (RW)
//
// Ports
//   clk      system / APB clock
//   preset   synchronous active-high reset
//   paddr    register address
//   psel     APB select
//   penable  APB access phase
//   pwrite   1 = write, 0 = read
//   pwdata   write data
//   prdata   read data (combinational, valid in the access phase)
//   pready   transfer complete (always zero wait states)
//   pslverr  transfer error (CURR write or address past the last channel)
//   irq      per-channel level interrupt, DONE & IRQ_EN
module apb_timer_bank #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [NUM_CH-1:0]     irq
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_PAUSED   = 2'd3
  } state_e;

  // Widening the address to 32 bits keeps the channel decode legal even when
  // only one channel exists (no zero-width channel field).
  logic [31:0] paddr_ext;
  logic        access;
  logic        addr_oob;
  logic        curr_wr;
  logic        xfer_err;
  logic        wr_en;
  logic [1:0]  reg_off;

  assign paddr_ext = 32'(paddr);
  assign access    = psel & penable;
  assign addr_oob  = (paddr_ext >= 32'(4 * NUM_CH));
  assign reg_off   = paddr_ext[1:0];
  assign curr_wr   = pwrite & (reg_off == 2'd2);
  assign xfer_err  = access & (addr_oob | curr_wr);
  assign wr_en     = access & pwrite & ~xfer_err;

  assign pready  = access;
  assign pslverr = xfer_err & ~preset;

  // STATUS bits above DONE are never stored.
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[DATA_WIDTH-1:7];

  logic [NUM_CH-1:0]                 ch_sel;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_rdata;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_e                state_q, state_d;
      logic [DATA_WIDTH-1:0] goal_q, goal_d;
      logic [DATA_WIDTH-1:0] curr_q, curr_d;
      logic [DATA_WIDTH-1:0] presc_q, presc_d;
      logic [DATA_WIDTH-1:0] psc_q, psc_d;
      logic                  reload_q, reload_d;
      logic                  irq_en_q, irq_en_d;
      logic                  done_q, done_d;
      logic                  wr_status, wr_goal, wr_presc;
      logic                  start_cmd, stop_cmd;
      logic [DATA_WIDTH:0]   curr_inc;
      logic [DATA_WIDTH-1:0] status_rd;

      assign ch_sel[gi] = (paddr_ext[31:2] == 30'(gi));
      assign wr_status  = wr_en & ch_sel[gi] & (reg_off == 2'd0);
      assign wr_goal    = wr_en & ch_sel[gi] & (reg_off == 2'd1);
      assign wr_presc   = wr_en & ch_sel[gi] & (reg_off == 2'd3);
      assign start_cmd  = wr_status & pwdata[0];
      assign stop_cmd   = wr_status & pwdata[1];

      // One extra bit so CURR+1 at the top of the range still compares
      // as >= GOAL instead of wrapping to zero.
      assign curr_inc = {1'b0, curr_q} + (DATA_WIDTH + 1)'(1);

      always_comb begin
        state_d  = state_q;
        goal_d   = goal_q;
        curr_d   = curr_q;
        presc_d  = presc_q;
        psc_d    = psc_q;
        reload_d = reload_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;

        if (wr_goal)  goal_d  = pwdata;
        if (wr_presc) presc_d = pwdata;
        if (wr_status) begin
          reload_d = pwdata[4];
          irq_en_d = pwdata[5];
          if (pwdata[6]) done_d = 1'b0;
        end

        // A STATUS command replaces counting for this cycle; STOP beats START.
        // Any DONE set below overrides a same-cycle W1C above.
        if (stop_cmd) begin
          if (state_q == ST_RUNNING) state_d = ST_PAUSED;
        end else if (start_cmd) begin
          if (state_q == ST_PAUSED) begin
            state_d = ST_RUNNING;
          end else if (goal_q == '0) begin
            curr_d  = '0;
            psc_d   = '0;
            done_d  = 1'b1;
            state_d = ST_COMPLETE;
          end else begin
            curr_d  = '0;
            psc_d   = '0;
            state_d = ST_RUNNING;
          end
        end else if (state_q == ST_RUNNING) begin
          if (psc_q == presc_q) begin
            psc_d = '0;
            if (curr_inc >= {1'b0, goal_q}) begin
              done_d = 1'b1;
              if (reload_q) begin
                curr_d = '0;
              end else begin
                curr_d  = goal_q;
                state_d = ST_COMPLETE;
              end
            end else begin
              curr_d = curr_inc[DATA_WIDTH-1:0];
            end
          end else begin
            psc_d = psc_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (preset) begin
          state_q  <= ST_IDLE;
          goal_q   <= '0;
          curr_q   <= '0;
          presc_q  <= '0;
          psc_q    <= '0;
          reload_q <= 1'b0;
          irq_en_q <= 1'b0;
          done_q   <= 1'b0;
        end else begin
          state_q  <= state_d;
          goal_q   <= goal_d;
          curr_q   <= curr_d;
          presc_q  <= presc_d;
          psc_q    <= psc_d;
          reload_q <= reload_d;
          irq_en_q <= irq_en_d;
          done_q   <= done_d;
        end
      end

      always_comb begin
        status_rd      = '0;
        status_rd[6:0] = {done_q, irq_en_q, reload_q, state_q, 2'b00};
      end

      always_comb begin
        case (reg_off)
          2'd0:    ch_rdata[gi] = status_rd;
          2'd1:    ch_rdata[gi] = goal_q;
          2'd2:    ch_rdata[gi] = curr_q;
          default: ch_rdata[gi] = presc_q;
        endcase
      end

      assign irq[gi] = done_q & irq_en_q;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) rd_mux = ch_rdata[c];
    end
  end

  assign prdata = (access & ~pwrite & ~addr_oob & ~preset) ? rd_mux : '0;

endmodule

// File: tb/tb_apb_timer_bank.sv
module tb_apb_timer_bank;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_CMP = 2, S_PAU = 3;

  logic          clk = 1'b0;
  logic          preset;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [NCH-1:0] irq;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural reference: plain integers per channel.
  int m_state[NCH];
  int m_curr[NCH];
  int m_goal[NCH];
  int m_presc[NCH];
  int m_pc[NCH];
  bit m_rl[NCH];
  bit m_ien[NCH];
  bit m_done[NCH];

  apb_timer_bank #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .preset(preset), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance the reference by one clock edge using the pins as they were
  // presented to that edge.
  function automatic void model_step();
    int a, off;
    bit wr, hit, set_done;
    if (preset) begin
      for (int c = 0; c < NCH; c++) begin
        m_state[c] = S_IDLE; m_curr[c] = 0; m_goal[c] = 0; m_presc[c] = 0;
        m_pc[c] = 0; m_rl[c] = 0; m_ien[c] = 0; m_done[c] = 0;
      end
      return;
    end
    a   = int'(paddr);
    off = a % 4;
    wr  = psel && penable && pwrite && (a < 4 * NCH) && (off != 2);
    for (int c = 0; c < NCH; c++) begin
      hit = wr && (a / 4 == c);
      set_done = 0;
      if (hit && off == 0 && pwdata[1]) begin
        if (m_state[c] == S_RUN) m_state[c] = S_PAU;
      end else if (hit && off == 0 && pwdata[0]) begin
        if (m_state[c] == S_PAU) m_state[c] = S_RUN;
        else if (m_goal[c] == 0) begin
          m_curr[c] = 0; m_pc[c] = 0; set_done = 1; m_state[c] = S_CMP;
        end else begin
          m_curr[c] = 0; m_pc[c] = 0; m_state[c] = S_RUN;
        end
      end else if (m_state[c] == S_RUN) begin
        if (m_pc[c] == m_presc[c]) begin
          m_pc[c] = 0;
          if (m_curr[c] + 1 >= m_goal[c]) begin
            set_done = 1;
            if (m_rl[c]) m_curr[c] = 0;
            else begin
              m_curr[c] = m_goal[c]; m_state[c] = S_CMP;
            end
          end else begin
            m_curr[c] = m_curr[c] + 1;
          end
        end else begin
          m_pc[c] = (m_pc[c] + 1) % 256;
        end
      end
      if (hit && off == 0) begin
        m_rl[c]  = pwdata[4];
        m_ien[c] = pwdata[5];
        if (pwdata[6]) m_done[c] = 0;
      end
      if (hit && off == 1) m_goal[c]  = int'(pwdata);
      if (hit && off == 3) m_presc[c] = int'(pwdata);
      if (set_done) m_done[c] = 1;
    end
  endfunction

  function automatic int mread(input int a);
    int c;
    if (a >= 4 * NCH) return 0;
    c = a / 4;
    case (a % 4)
      0:       return (int'(m_done[c]) << 6) | (int'(m_ien[c]) << 5) |
                      (int'(m_rl[c]) << 4) | (m_state[c] << 2);
      1:       return m_goal[c];
      2:       return m_curr[c];
      default: return m_presc[c];
    endcase
  endfunction

  function automatic int model_irq();
    int v;
    v = 0;
    for (int c = 0; c < NCH; c++) if (m_done[c] && m_ien[c]) v |= (1 << c);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
    check("idle/irq", 32'(irq), 32'(model_irq()));
  endtask

  task automatic apb(input bit wr, input int addr, input int data, input string tag,
                     output logic [31:0] rdata, output logic err);
    bit exp_err;
    int exp_rd;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr[AW-1:0]; pwdata = data[DW-1:0];
    cycle();
    penable = 1'b1;
    #1;
    rdata   = 32'(prdata);
    err     = pslverr;
    exp_err = (addr >= 4 * NCH) || (wr && (addr % 4 == 2));
    exp_rd  = wr ? 0 : mread(addr);
    check({tag, "/pready"}, 32'(pready), 32'd1);
    check({tag, "/pslverr"}, 32'(err), 32'(exp_err));
    if (!wr) check({tag, "/prdata"}, rdata, 32'(exp_rd));
    cycle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check({tag, "/irq"}, 32'(irq), 32'(model_irq()));
    $display("apb %s addr=%0d data=0x%0h rdata=0x%0h err=%0b [%s]",
             wr ? "WR" : "RD", addr, data, rdata, err, tag);
  endtask

  task automatic wr(input int addr, input int data, input string tag);
    logic [31:0] v;
    logic e;
    apb(1'b1, addr, data, tag, v, e);
  endtask

  task automatic rd(input int addr, input string tag, output logic [31:0] v);
    logic e;
    apb(1'b0, addr, 0, tag, v, e);
  endtask

  initial begin
    logic [31:0] v;
    logic        e;
    int          saved;
    int          ra, rd_d;
    bit          rw;

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    cycle(); cycle();
    preset = 1'b0;
    check("reset/irq", 32'(irq), 32'd0);

    // Reset in the middle of a run.
    wr(1, 100, "ch0_goal");
    wr(0, 8'h01, "ch0_start");
    idle(4);
    rd(2, "ch0_curr_run", v);
    preset = 1'b1;
    cycle();
    preset = 1'b0;
    check("rst_mid/irq", 32'(irq), 32'd0);
    for (int c = 0; c < NCH; c++) begin
      rd(4 * c, "rst_status", v);
      check("rst_status_zero", v, 32'd0);
      rd(4 * c + 2, "rst_curr", v);
      check("rst_curr_zero", v, 32'd0);
    end

    // ch1 one-shot, GOAL=10, PRESC=0, with interrupt.
    wr(5, 10, "ch1_goal");
    wr(7, 0, "ch1_presc");
    wr(4, 8'h21, "ch1_start");
    rd(4, "ch1_status_run", v);
    check("ch1_state_running", v, 32'h24);
    idle(12);
    rd(4, "ch1_status_done", v);
    check("ch1_state_complete", v, 32'h68);
    rd(6, "ch1_curr_done", v);
    check("ch1_curr_goal", v, 32'd10);
    check("ch1_irq_high", 32'(irq[1]), 32'd1);
    wr(4, 8'h60, "ch1_w1c");
    check("ch1_irq_low", 32'(irq[1]), 32'd0);

    // ch2 auto-reload, GOAL=3, PRESC=2.
    wr(9, 3, "ch2_goal");
    wr(11, 2, "ch2_presc");
    wr(8, 8'h11, "ch2_start");
    for (int k = 0; k < 4; k++) begin
      rd(10, "ch2_curr", v);
      idle(1);
    end
    idle(6);
    rd(8, "ch2_status", v);
    check("ch2_done_running", v, 32'h54);

    // Pause / resume on ch0.
    wr(1, 200, "ch0_goal200");
    wr(0, 8'h01, "ch0_start");
    idle(18);
    wr(0, 8'h02, "ch0_stop");
    rd(2, "pause_a", v);
    saved = m_curr[0];
    idle(10);
    rd(2, "pause_b", v);
    check("pause_hold", v, 32'(saved));
    rd(0, "pause_status", v);
    check("pause_state", v, 32'h0C);

    // Errors: CURR write, out-of-range read, setup phase only.
    apb(1'b1, 2, 8'h55, "curr_wr", v, e);
    check("curr_wr_err", 32'(e), 32'd1);
    rd(2, "curr_after_wr", v);
    check("curr_unchanged", v, 32'(saved));
    apb(1'b0, 16, 0, "oob_rd", v, e);
    check("oob_err", 32'(e), 32'd1);
    check("oob_data", v, 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd1; pwdata = 8'h77;
    cycle();
    check("nopen_pready", 32'(pready), 32'd0);
    check("nopen_pslverr", 32'(pslverr), 32'd0);
    cycle();
    psel = 1'b0; pwrite = 1'b0;
    rd(1, "nopen_goal", v);
    check("nopen_goal_kept", v, 32'd200);

    // Resume keeps the paused value.
    wr(0, 8'h01, "ch0_resume");
    idle(5);
    rd(2, "resume_curr", v);
    check("resume_advanced", 32'(v > 32'(saved)), 32'd1);

    // START+STOP together on idle ch3, then GOAL=0 START.
    wr(12, 8'h03, "ch3_startstop");
    rd(12, "ch3_status_idle", v);
    check("ch3_stays_idle", v, 32'd0);
    wr(12, 8'h21, "ch3_goal0_start");
    check("ch3_irq_next_edge", 32'(irq[3]), 32'd1);
    rd(12, "ch3_status_cmp", v);
    check("ch3_complete", v, 32'h68);

    // ch0 and ch1 running at the same time.
    wr(1, 7, "ch0_goal7");
    wr(3, 0, "ch0_presc0");
    wr(5, 13, "ch1_goal13");
    wr(7, 1, "ch1_presc1");
    wr(0, 8'h01, "ch0_go");
    wr(4, 8'h01, "ch1_go");
    idle(40);
    rd(0, "conc_st0", v);
    check("conc_ch0_complete", v, 32'h48);
    rd(4, "conc_st1", v);
    check("conc_ch1_complete", v, 32'h48);
    rd(2, "conc_curr0", v);
    check("conc_ch0_curr", v, 32'd7);
    rd(6, "conc_curr1", v);
    check("conc_ch1_curr", v, 32'd13);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      ra   = int'($urandom_range(0, 4 * NCH + 3));
      rw   = 1'($urandom_range(0, 1));
      rd_d = int'($urandom_range(0, 255));
      if (ra % 4 == 3 && rw) rd_d = rd_d % 4;
      apb(rw, ra, rd_d, "rand", v, e);
      idle(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
